// File: rtl/fp_dot_pkg.sv
// Shared types and constants for the streaming floating-point dot-product engine.
package fp_dot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int STAT_ZERO    = 0;
    localparam int STAT_INF     = 1;
    localparam int STAT_INVALID = 2;
    localparam int STAT_TINY    = 3;
    localparam int STAT_HUGE    = 4;
    localparam int STAT_INEXACT = 5;

    localparam logic [7:0] STAT_STICKY_MASK = 8'hFC;

    function automatic logic [63:0] fp_one(input int sig_w, input int exp_w);
        logic [63:0] bias;
        bias = (64'd1 << (exp_w - 1)) - 64'd1;
        return bias << sig_w;
    endfunction

endpackage

// File: rtl/fp_dot_stream_dp2.sv
// Combinational fused two-term dot product z = a*b + c*d with a single rounding,
// port- and status-compatible with DW_fp_dp2.
module fp_dot_stream_dp2
    import fp_dot_pkg::*;
#(
    parameter int SIG_WIDTH       = 23,
    parameter int EXP_WIDTH       = 8,
    parameter int IEEE_COMPLIANCE = 0,
    parameter int ARCH_TYPE       = 0
) (
    input  logic [SIG_WIDTH+EXP_WIDTH:0] a_i,
    input  logic [SIG_WIDTH+EXP_WIDTH:0] b_i,
    input  logic [SIG_WIDTH+EXP_WIDTH:0] c_i,
    input  logic [SIG_WIDTH+EXP_WIDTH:0] d_i,
    input  logic [2:0]                   rnd_i,
    output logic [SIG_WIDTH+EXP_WIDTH:0] z_o,
    output logic [7:0]                   status_o
);
    localparam int W    = SIG_WIDTH + EXP_WIDTH + 1;
    localparam int S    = SIG_WIDTH;
    localparam int PW   = 2 * S + 2;
    localparam int L    = 2 * PW + 4;
    localparam int OFF  = L - 1 - PW;
    localparam int XW   = EXP_WIDTH + 4;
    localparam int SHW  = $clog2(L + 1);
    localparam int BIAS = (1 << (EXP_WIDTH - 1)) - 1;
    localparam int EMAX = (1 << EXP_WIDTH) - 1;

    localparam logic signed [XW-1:0] X_ONE  = XW'(1);
    localparam logic signed [XW-1:0] X_TWO  = XW'(2);
    localparam logic signed [XW-1:0] X_BIAS = XW'(BIAS);
    localparam logic signed [XW-1:0] X_EMAX = XW'(EMAX);
    localparam logic signed [XW-1:0] X_L    = XW'(L);
    localparam logic signed [XW-1:0] X_ZSEN = XW'(-(1 << (XW - 2)));

    typedef struct packed {
        logic                 s;
        logic                 zero;
        logic                 inf;
        logic                 nan;
        logic [S:0]           m;
        logic signed [XW-1:0] e;
    } opnd_t;

    // Area/speed selection has no effect on this behavioural datapath.
    logic arch_unused;
    assign arch_unused = (ARCH_TYPE != 0);

    function automatic opnd_t unpack(input logic [W-1:0] v);
        opnd_t                o;
        logic [EXP_WIDTH-1:0] ef;
        logic [S-1:0]         ff;
        ef     = v[W-2:S];
        ff     = v[S-1:0];
        o.s    = v[W-1];
        o.nan  = (&ef) && (|ff);
        o.inf  = (&ef) && !(|ff);
        o.zero = (ef == '0) && ((IEEE_COMPLIANCE == 0) || (ff == '0));
        o.m    = {(ef != '0), ff};
        o.e    = $signed(XW'((ef == '0) ? EXP_WIDTH'(1) : ef)) - X_BIAS;
        return o;
    endfunction

    function automatic logic round_inc(input logic [2:0] mode, input logic sgn,
                                       input logic lsb, input logic g, input logic st);
        case (mode)
            3'd1:    return 1'b0;
            3'd2:    return !sgn && (g || st);
            3'd3:    return sgn && (g || st);
            3'd4:    return g;
            3'd5:    return g || st;
            default: return g && (st || lsb);
        endcase
    endfunction

    function automatic logic ovf_to_inf(input logic [2:0] mode, input logic sgn);
        case (mode)
            3'd1:    return 1'b0;
            3'd2:    return !sgn;
            3'd3:    return sgn;
            default: return 1'b1;
        endcase
    endfunction

    // Right shift returning {shifted value, OR of bits shifted out}.
    function automatic logic [L:0] shr_sticky(input logic [L-1:0] v, input logic [SHW-1:0] sh);
        logic [L-1:0] mask;
        mask = ~({L{1'b1}} << sh);
        return {v >> sh, |(v & mask)};
    endfunction

    opnd_t                oa, ob, oc, od;
    logic [PW-1:0]        p1, p2, pbig, psml;
    logic signed [XW-1:0] e1, e2, ebig, esml, diff, eres, ebias, efin;
    logic                 s1, s2, sbig, ssml, z1, z2, inf1, inf2;
    logic                 nan_in, invalid, rsign, zsign, denorm, st_x, g, st, inc;
    logic [L-1:0]         bigbuf, smlfull, smlbuf, sum, norm, fin;
    logic [L:0]           shres, shres2;
    logic [SHW-1:0]       sh, lz, dsh;
    logic [S:0]           mant;
    logic [S+1:0]         mr;
    logic [S-1:0]         frac;

    always_comb begin
        oa = unpack(a_i);
        ob = unpack(b_i);
        oc = unpack(c_i);
        od = unpack(d_i);

        s1      = oa.s ^ ob.s;
        s2      = oc.s ^ od.s;
        z1      = oa.zero || ob.zero;
        z2      = oc.zero || od.zero;
        inf1    = oa.inf || ob.inf;
        inf2    = oc.inf || od.inf;
        nan_in  = oa.nan || ob.nan || oc.nan || od.nan;
        invalid = (inf1 && z1) || (inf2 && z2) || (inf1 && inf2 && (s1 != s2));

        // Exact products; a zero product gets a sentinel exponent so it always aligns below.
        p1 = z1 ? '0 : PW'(oa.m) * PW'(ob.m);
        p2 = z2 ? '0 : PW'(oc.m) * PW'(od.m);
        e1 = z1 ? X_ZSEN : $signed(oa.e) + $signed(ob.e);
        e2 = z2 ? X_ZSEN : $signed(oc.e) + $signed(od.e);

        if (e2 > e1) begin
            pbig = p2; ebig = e2; sbig = s2;
            psml = p1; esml = e1; ssml = s1;
        end else begin
            pbig = p1; ebig = e1; sbig = s1;
            psml = p2; esml = e2; ssml = s2;
        end

        diff    = ebig - esml;
        sh      = (diff > X_L) ? SHW'(L) : SHW'(diff);
        bigbuf  = {1'b0, pbig, {OFF{1'b0}}};
        smlfull = {1'b0, psml, {OFF{1'b0}}};
        shres   = shr_sticky(smlfull, sh);
        smlbuf  = shres[L:1] | {{(L-1){1'b0}}, shres[0]};

        if (sbig == ssml) begin
            sum = bigbuf + smlbuf;  rsign = sbig;
        end else if (bigbuf >= smlbuf) begin
            sum = bigbuf - smlbuf;  rsign = sbig;
        end else begin
            sum = smlbuf - bigbuf;  rsign = ssml;
        end

        lz = '0;
        for (int i = 0; i < L; i++) begin
            if (sum[i]) lz = SHW'(L - 1 - i);
        end
        norm  = sum << lz;
        eres  = ebig + X_TWO - $signed(XW'(lz));
        ebias = eres + X_BIAS;

        denorm = 1'b0;
        dsh    = '0;
        shres2 = '0;
        fin    = norm;
        st_x   = 1'b0;
        if ((IEEE_COMPLIANCE != 0) && (ebias < X_ONE)) begin
            denorm = 1'b1;
            dsh    = ((X_ONE - ebias) > X_L) ? SHW'(L) : SHW'(X_ONE - ebias);
            shres2 = shr_sticky(norm, dsh);
            fin    = shres2[L:1];
            st_x   = shres2[0];
        end

        mant = fin[L-1 -: S+1];
        g    = fin[L-2-S];
        st   = (|fin[L-3-S:0]) || st_x;
        inc  = round_inc(rnd_i, rsign, mant[0], g, st);
        mr   = {1'b0, mant} + (S+2)'(inc);
        frac = mr[S+1] ? mr[S:1] : mr[S-1:0];
        if (denorm) efin = mr[S] ? X_ONE : '0;
        else        efin = ebias + (mr[S+1] ? X_ONE : '0);

        zsign = (z1 && z2) ? ((rnd_i == 3'd3) ? (s1 || s2) : (s1 && s2)) : (rnd_i == 3'd3);

        z_o      = '0;
        status_o = '0;
        if (nan_in || invalid) begin
            z_o = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(S-1){1'b0}}};
            status_o[STAT_INVALID] = invalid;
        end else if (inf1 || inf2) begin
            z_o = {(inf1 ? s1 : s2), {EXP_WIDTH{1'b1}}, {S{1'b0}}};
            status_o[STAT_INF] = 1'b1;
        end else if (sum == '0) begin
            z_o = {zsign, {(W-1){1'b0}}};
            status_o[STAT_ZERO] = 1'b1;
        end else if (!denorm && (ebias < X_ONE)) begin
            z_o = {rsign, {(W-1){1'b0}}};
            status_o[STAT_ZERO]    = 1'b1;
            status_o[STAT_TINY]    = 1'b1;
            status_o[STAT_INEXACT] = 1'b1;
        end else if (efin >= X_EMAX) begin
            status_o[STAT_HUGE]    = 1'b1;
            status_o[STAT_INEXACT] = 1'b1;
            if (ovf_to_inf(rnd_i, rsign)) begin
                z_o = {rsign, {EXP_WIDTH{1'b1}}, {S{1'b0}}};
                status_o[STAT_INF] = 1'b1;
            end else begin
                z_o = {rsign, EXP_WIDTH'(EMAX - 1), {S{1'b1}}};
            end
        end else begin
            z_o = {rsign, efin[EXP_WIDTH-1:0], frac};
            status_o[STAT_INEXACT] = g || st;
            status_o[STAT_TINY]    = denorm;
            status_o[STAT_ZERO]    = (efin == '0) && (frac == '0);
        end
    end

endmodule

// File: rtl/fp_dot_stream.sv
// Streaming dot-product engine: accumulates x*y pairs into acc via one fused
// acc*1.0 + x*y step per accepted beat and hands one result per vector downstream.
module fp_dot_stream
    import fp_dot_pkg::*;
#(
    parameter int SIG_WIDTH       = 23,
    parameter int EXP_WIDTH       = 8,
    parameter int IEEE_COMPLIANCE = 0,
    parameter int ARCH_TYPE       = 0,
    parameter int CNT_W           = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2:0]                   rnd,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SIG_WIDTH+EXP_WIDTH:0] in_x,
    input  logic [SIG_WIDTH+EXP_WIDTH:0] in_y,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SIG_WIDTH+EXP_WIDTH:0] out_z,
    output logic [7:0]                   out_status,
    output logic [CNT_W-1:0]             out_count
);
    localparam int W = SIG_WIDTH + EXP_WIDTH + 1;
    localparam logic [W-1:0] FP_ONE = W'(fp_one(SIG_WIDTH, EXP_WIDTH));

    state_e           state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [7:0]       stat_q, stat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     dp_z;
    logic [7:0]       dp_status;
    logic             accept;

    fp_dot_stream_dp2 #(
        .SIG_WIDTH       (SIG_WIDTH),
        .EXP_WIDTH       (EXP_WIDTH),
        .IEEE_COMPLIANCE (IEEE_COMPLIANCE),
        .ARCH_TYPE       (ARCH_TYPE)
    ) u_dp2 (
        .a_i      (acc_q),
        .b_i      (FP_ONE),
        .c_i      (in_x),
        .d_i      (in_y),
        .rnd_i    (rnd),
        .z_o      (dp_z),
        .status_o (dp_status)
    );

    // Ready depends on registered state only, so a pop never admits a pair in the same cycle.
    assign in_ready = (state_q != DONE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        stat_d  = stat_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_d   = dp_z;
                    stat_d  = ((stat_q | dp_status) & STAT_STICKY_MASK) |
                              (dp_status & ~STAT_STICKY_MASK);
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                    state_d = in_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    stat_d  = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            stat_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            stat_q  <= stat_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid  = (state_q == DONE);
    assign out_z      = acc_q;
    assign out_status = stat_q;
    assign out_count  = cnt_q;

endmodule
